// File: rtl/game_state_master.sv
// Master game sequencer: Idle/Play/Win/Lose, score keeping, timed end screens
// and the one-cycle start-of-game reset pulse for the snake datapath.
module game_state_master #(
    parameter int TARGET_SCORE = 10,
    parameter int SCORE_W      = 4,
    parameter int END_HOLD     = 200000000,
    parameter int HOLD_W       = 28
) (
    input  logic               CLK,
    input  logic               RESETn,
    input  logic               BTN_Start,
    input  logic               Food_Eaten,
    input  logic               Fail,
    output logic [1:0]         Play_State,
    output logic [SCORE_W-1:0] Score,
    output logic               Game_Reset
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        WIN  = 2'b10,
        LOSE = 2'b11
    } state_t;

    localparam logic [SCORE_W-1:0] SCORE_LAST = SCORE_W'(TARGET_SCORE - 1);
    localparam logic [SCORE_W-1:0] SCORE_WIN  = SCORE_W'(TARGET_SCORE);
    localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(END_HOLD - 1);
    localparam logic [HOLD_W-1:0]  HOLD_ONE   = HOLD_W'(1);

    state_t            state;
    logic [HOLD_W-1:0] hold_cnt;
    logic              sync1;
    logic              sync2;
    logic              sync3;
    logic              start_edge;

    // Two-flop synchroniser plus one edge register for the raw button.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= BTN_Start;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign start_edge = sync2 & ~sync3;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state      <= IDLE;
            Score      <= '0;
            Game_Reset <= 1'b0;
            hold_cnt   <= '0;
        end else begin
            Game_Reset <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        state      <= PLAY;
                        Score      <= '0;
                        Game_Reset <= 1'b1;
                    end
                end
                PLAY: begin
                    // A collision outranks food arriving in the same cycle.
                    if (Fail) begin
                        state    <= LOSE;
                        hold_cnt <= '0;
                    end else if (Food_Eaten) begin
                        if (Score == SCORE_LAST) begin
                            Score    <= SCORE_WIN;
                            state    <= WIN;
                            hold_cnt <= '0;
                        end else begin
                            Score <= Score + SCORE_ONE;
                        end
                    end
                end
                WIN, LOSE: begin
                    // Score stays frozen on the end screen and back in Idle.
                    if (hold_cnt == HOLD_LAST) begin
                        state <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign Play_State = state;

endmodule
